// File: rtl/elev_pkg.sv
// Shared types and helpers for the elevator call panel: floor count, FSM states,
// direction encoding, floor index type and the call-selection function.
package elev_pkg;

   localparam int NFLR = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   // Floor index, encoded 1..NFLR.
   typedef logic [1:0] flr_t;

   typedef logic [NFLR:1] floors_t;

   typedef struct packed {
      logic valid;
      flr_t flr;
      logic dir;
   } sel_t;

   function automatic floors_t flr_onehot(input flr_t f);
      floors_t one;
      one = {{(NFLR-1){1'b0}}, 1'b1};
      return one << (f - 2'd1);
   endfunction

   // Priority: call at current floor, nearest ahead in dir, nearest behind (dir flips).
   function automatic sel_t select_target(input floors_t avail, input flr_t cur, input logic dir);
      sel_t sel;
      logic up_ok;
      logic dn_ok;
      flr_t up_f;
      flr_t dn_f;
      up_ok = 1'b0;
      dn_ok = 1'b0;
      up_f  = cur;
      dn_f  = cur;
      for (int i = NFLR; i >= 1; i--) begin
         if ((i > int'(cur)) && avail[i]) begin
            up_ok = 1'b1;
            up_f  = flr_t'(i);
         end
      end
      for (int i = 1; i <= NFLR; i++) begin
         if ((i < int'(cur)) && avail[i]) begin
            dn_ok = 1'b1;
            dn_f  = flr_t'(i);
         end
      end
      sel.valid = |avail;
      sel.flr   = cur;
      sel.dir   = dir;
      if (!sel.valid || avail[cur]) begin
         sel.flr = cur;
      end else if ((dir == DIR_UP) && up_ok) begin
         sel.flr = up_f;
      end else if ((dir == DIR_DN) && dn_ok) begin
         sel.flr = dn_f;
      end else if (dir == DIR_UP) begin
         sel.flr = dn_f;
         sel.dir = DIR_DN;
      end else begin
         sel.flr = up_f;
         sel.dir = DIR_UP;
      end
      return sel;
   endfunction

endpackage

// File: rtl/elev_call_panel_if.sv
// Pin-side bundle of the call panel: buttons and sensor in, controller feedback in,
// controller request/obstruction and lamp outputs out.
interface elev_call_panel_if;
   import elev_pkg::*;

   floors_t Btn;
   logic    Obst_raw;
   logic    FLR1;
   logic    FLR2;
   logic    FLR3;
   logic    Door;
   floors_t Req;
   logic    Blk;
   floors_t Pend;

   modport master (
      input  Btn, Obst_raw, FLR1, FLR2, FLR3, Door,
      output Req, Blk, Pend
   );

   modport slave (
      output Btn, Obst_raw, FLR1, FLR2, FLR3, Door,
      input  Req, Blk, Pend
   );

endinterface

// File: rtl/elev_blk_debounce.sv
// Obstruction conditioner: Blk follows Obst_raw only after DB_CYCLES consecutive
// disagreeing samples (used when ELEV_CALL_BLK_DEBOUNCE_EN is defined).
module elev_blk_debounce #(
   parameter int unsigned DB_CYCLES = 3
) (
   input  logic clk,
   input  logic Reset,
   input  logic obst_raw,
   output logic blk
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [CW-1:0] cnt_r;
   logic          blk_r;

   // Stability counter and conditioned output register.
   always_ff @(posedge clk) begin
      if (Reset) begin
         cnt_r <= {CW{1'b0}};
         blk_r <= 1'b0;
      end else if (obst_raw != blk_r) begin
         if (cnt_r == CW'(DB_CYCLES - 32'd1)) begin
            blk_r <= obst_raw;
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end else begin
         cnt_r <= {CW{1'b0}};
      end
   end

   assign blk = blk_r;

endmodule

// File: rtl/elev_call_panel.sv
// Call-panel front end: latches button presses, issues one locked request at a time
// to the controller, and conditions the obstruction sensor (ELEV_CALL_BLK_DEBOUNCE_EN).
module elev_call_panel
   import elev_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned DB_CYCLES  = 3
) (
   input  logic                clk,
   input  logic                Reset,
   elev_call_panel_if.master   bus
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   floors_t       btn_r;
   floors_t       pend_r;
   floors_t       req_r;
   flr_t          cur_flr_r;
   flr_t          tgt_r;
   logic          dir_r;
   state_t        state_r;
   logic [GW-1:0] gap_r;
   logic          blk_s;

   floors_t       flr_s;
   floors_t       rise_s;
   floors_t       clr_s;
   floors_t       avail_s;
   sel_t          sel_s;

   // Edge detect, service detection and next-target choice.
   always_comb begin
      flr_s   = {bus.FLR3, bus.FLR2, bus.FLR1};
      rise_s  = bus.Btn & ~btn_r;
      clr_s   = flr_s & {NFLR{bus.Door}};
      // A call being served this very edge must not be issued.
      avail_s = pend_r & ~clr_s;
      sel_s   = select_target(avail_s, cur_flr_r, dir_r);
   end

   // Call latching, floor tracking and the request FSM.
   always_ff @(posedge clk) begin
      if (Reset) begin
         btn_r     <= {NFLR{1'b0}};
         pend_r    <= {NFLR{1'b0}};
         req_r     <= {NFLR{1'b0}};
         cur_flr_r <= 2'd1;
         tgt_r     <= 2'd1;
         dir_r     <= DIR_UP;
         state_r   <= IDLE;
         gap_r     <= {GW{1'b0}};
      end else begin
         btn_r  <= bus.Btn;
         pend_r <= (pend_r | rise_s) & ~clr_s;
         case (flr_s)
            3'b001:  cur_flr_r <= 2'd1;
            3'b010:  cur_flr_r <= 2'd2;
            3'b100:  cur_flr_r <= 2'd3;
            default: cur_flr_r <= cur_flr_r;
         endcase
         case (state_r)
            IDLE: begin
               if (sel_s.valid) begin
                  tgt_r   <= sel_s.flr;
                  dir_r   <= sel_s.dir;
                  req_r   <= flr_onehot(sel_s.flr);
                  state_r <= SERVE;
               end else begin
                  req_r   <= {NFLR{1'b0}};
               end
            end
            SERVE: begin
               if (clr_s[tgt_r]) begin
                  req_r   <= {NFLR{1'b0}};
                  gap_r   <= GW'(GAP_CYCLES - 32'd1);
                  state_r <= GAP;
               end else begin
                  req_r   <= req_r;
               end
            end
            GAP: begin
               req_r <= {NFLR{1'b0}};
               if (gap_r == {GW{1'b0}}) begin
                  state_r <= IDLE;
               end else begin
                  gap_r   <= gap_r - GW'(1);
               end
            end
            default: begin
               req_r   <= {NFLR{1'b0}};
               state_r <= IDLE;
            end
         endcase
      end
   end

`ifdef ELEV_CALL_BLK_DEBOUNCE_EN
   elev_blk_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_blk_debounce (
      .clk      (clk),
      .Reset    (Reset),
      .obst_raw (bus.Obst_raw),
      .blk      (blk_s)
   );
`else
   logic        blk_r;
   logic [31:0] unused_db_s;

   assign unused_db_s = DB_CYCLES;

   // Plain one-register retiming of the obstruction sensor.
   always_ff @(posedge clk) begin
      if (Reset) begin
         blk_r <= 1'b0;
      end else begin
         blk_r <= bus.Obst_raw;
      end
   end

   assign blk_s = blk_r;
`endif

   assign bus.Req  = req_r;
   assign bus.Pend = pend_r;
   assign bus.Blk  = blk_s;

endmodule

// File: tb/tb_elev_call_panel.sv
// Directed bench for elev_call_panel with a per-cycle reference model and literal checks.
module tb_elev_call_panel;

   localparam int GAP = 4;
   localparam int DB  = 3;

   logic clk;
   logic Reset;
   int   n_checks;
   int   n_fail;

   elev_call_panel_if bus ();

   elev_call_panel #(
      .GAP_CYCLES (GAP),
      .DB_CYCLES  (DB)
   ) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: mode 0 = waiting, 1 = request out, 2 = post-serve pause.
   bit m_pend [1:3];
   bit m_prev [1:3];
   int m_mode;
   int m_tgt;
   int m_cur;
   int m_dir;
   int m_gap_left;
   bit m_blk;
   int m_streak;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_req();
      logic [2:0] one;
      one = 3'b001;
      return (m_mode == 1) ? (one << (m_tgt - 1)) : 3'b000;
   endfunction

   function automatic logic [2:0] exp_pend();
      return {m_pend[3], m_pend[2], m_pend[1]};
   endfunction

   // Model update at each rising edge, compare at each falling edge.
   initial begin
      bit served [1:3];
      bit flr    [1:3];
      int pick;
      int f;
      int nhot;
      int hot;
      forever begin
         @(posedge clk);
         if (Reset) begin
            for (int n = 1; n <= 3; n++) begin
               m_pend[n] = 1'b0;
               m_prev[n] = 1'b0;
            end
            m_mode = 0; m_tgt = 1; m_cur = 1; m_dir = 1; m_gap_left = 0;
            m_blk = 1'b0; m_streak = 0;
         end else begin
            flr[1] = bus.FLR1; flr[2] = bus.FLR2; flr[3] = bus.FLR3;
            for (int n = 1; n <= 3; n++) served[n] = flr[n] && bus.Door;
            if (m_mode == 0) begin
               pick = 0;
               if (m_pend[m_cur] && !served[m_cur]) pick = m_cur;
               for (int d = 1; d <= 2; d++) begin
                  f = m_cur + m_dir * d;
                  if (pick == 0 && f >= 1 && f <= 3) begin
                     if (m_pend[f] && !served[f]) pick = f;
                  end
               end
               for (int d = 1; d <= 2; d++) begin
                  f = m_cur - m_dir * d;
                  if (pick == 0 && f >= 1 && f <= 3) begin
                     if (m_pend[f] && !served[f]) begin
                        pick  = f;
                        m_dir = -m_dir;
                     end
                  end
               end
               if (pick != 0) begin
                  m_tgt  = pick;
                  m_mode = 1;
               end
            end else if (m_mode == 1) begin
               if (served[m_tgt]) begin
                  m_mode     = 2;
                  m_gap_left = GAP;
               end
            end else begin
               m_gap_left--;
               if (m_gap_left == 0) m_mode = 0;
            end
            for (int n = 1; n <= 3; n++) begin
               m_pend[n] = (m_pend[n] || (bus.Btn[n] && !m_prev[n])) && !served[n];
               m_prev[n] = bus.Btn[n];
            end
            nhot = 0; hot = 0;
            for (int n = 1; n <= 3; n++) if (flr[n]) begin nhot++; hot = n; end
            if (nhot == 1) m_cur = hot;
`ifdef ELEV_CALL_BLK_DEBOUNCE_EN
            if (bus.Obst_raw != m_blk) begin
               m_streak++;
               if (m_streak >= DB) begin
                  m_blk    = bus.Obst_raw;
                  m_streak = 0;
               end
            end else begin
               m_streak = 0;
            end
`else
            m_blk = bus.Obst_raw;
`endif
         end
         @(negedge clk);
         chk("model_req",   bus.Req,  exp_req());
         chk("model_pend",  bus.Pend, exp_pend());
         chk("model_blk",   bus.Blk,  m_blk);
         chk("req_onehot",  ($countones(bus.Req) <= 1), 1'b1);
         chk("req_in_pend", ((bus.Req & ~bus.Pend) == 3'b000), 1'b1);
      end
   end

   task automatic wait_req(input logic [2:0] want, input int budget, input string name);
      int k;
      k = 0;
      while (bus.Req !== want && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, bus.Req, want);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      Reset = 1'b1;
      bus.Btn = 3'b000; bus.Obst_raw = 1'b0; bus.Door = 1'b0;
      bus.FLR1 = 1'b0; bus.FLR2 = 1'b0; bus.FLR3 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req",  bus.Req,  3'b000);
      chk("rst_pend", bus.Pend, 3'b000);
      chk("rst_blk",  bus.Blk,  1'b0);
      Reset = 1'b0;
      @(negedge clk);

      // Single call at floor 2, then serve and gap.
      bus.Btn = 3'b010;
      @(negedge clk);
      chk("t1_pend", bus.Pend, 3'b010);
      chk("t1_req_not_yet", bus.Req, 3'b000);
      bus.Btn = 3'b000;
      @(negedge clk);
      chk("t1_req", bus.Req, 3'b010);
      bus.FLR2 = 1'b1; bus.Door = 1'b1;
      @(negedge clk);
      chk("t1_served_pend", bus.Pend, 3'b000);
      chk("t1_served_req",  bus.Req,  3'b000);
      bus.Door = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_gap_req", bus.Req, 3'b000);
      end
      bus.FLR2 = 1'b0;

      // Direction priority: at floor 2 going up, calls at 1 and 3.
      bus.Btn = 3'b101;
      @(negedge clk);
      bus.Btn = 3'b000;
      chk("t2_pend", bus.Pend, 3'b101);
      @(negedge clk);
      chk("t2_req_up", bus.Req, 3'b100);
      bus.FLR3 = 1'b1; bus.Door = 1'b1;
      @(negedge clk);
      chk("t2_served_pend", bus.Pend, 3'b001);
      bus.Door = 1'b0;
      wait_req(3'b001, 12, "t2_req_reverse");
      chk("t2_model_dir", m_dir, -1);
      bus.FLR3 = 1'b0; bus.FLR1 = 1'b1; bus.Door = 1'b1;
      @(negedge clk);
      chk("t2_final_pend", bus.Pend, 3'b000);
      bus.Door = 1'b0;

      // Held button through a full serve at floor 1.
      bus.Btn = 3'b001;
      @(negedge clk);
      chk("t3_pend", bus.Pend, 3'b001);
      wait_req(3'b001, 12, "t3_req");
      bus.Door = 1'b1;
      @(negedge clk);
      chk("t3_served", bus.Pend, 3'b000);
      bus.Door = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t3_held_no_relatch", bus.Pend, 3'b000);
      end
      bus.Btn = 3'b000;

      // Clear beats set at floor 3.
      bus.FLR1 = 1'b0; bus.FLR3 = 1'b1; bus.Door = 1'b1; bus.Btn = 3'b100;
      @(negedge clk);
      chk("t4_clear_beats_set", bus.Pend, 3'b000);
      bus.Btn = 3'b000; bus.Door = 1'b0;
      @(negedge clk);
      chk("t4_no_req", bus.Req, 3'b000);

      // Reset in the middle of a SERVE.
      bus.Btn = 3'b110;
      @(negedge clk);
      bus.Btn = 3'b000;
      chk("t5_pend", bus.Pend, 3'b110);
      @(negedge clk);
      chk("t5_req", bus.Req, 3'b100);
      Reset = 1'b1;
      @(negedge clk);
      chk("t5_rst_req",  bus.Req,  3'b000);
      chk("t5_rst_pend", bus.Pend, 3'b000);
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_idle_after_rst", bus.Req, 3'b000);
      end

      // Obstruction conditioning: short glitch, then a stable assertion.
      bus.Obst_raw = 1'b1;
      @(negedge clk);
`ifdef ELEV_CALL_BLK_DEBOUNCE_EN
      chk("t6_glitch1", bus.Blk, 1'b0);
`else
      chk("t6_follow1", bus.Blk, 1'b1);
`endif
      @(negedge clk);
`ifdef ELEV_CALL_BLK_DEBOUNCE_EN
      chk("t6_glitch2", bus.Blk, 1'b0);
`else
      chk("t6_follow2", bus.Blk, 1'b1);
`endif
      bus.Obst_raw = 1'b0;
      @(negedge clk);
      chk("t6_low", bus.Blk, 1'b0);
      repeat (2) @(negedge clk);
      bus.Obst_raw = 1'b1;
      @(negedge clk);
      @(negedge clk);
`ifdef ELEV_CALL_BLK_DEBOUNCE_EN
      chk("t6_two_samples", bus.Blk, 1'b0);
`else
      chk("t6_two_samples", bus.Blk, 1'b1);
`endif
      @(negedge clk);
      chk("t6_three_samples", bus.Blk, 1'b1);
      bus.Obst_raw = 1'b0;
      repeat (4) @(negedge clk);

      // Multi-hot floor feedback is ignored; sweep down from floor 3.
      bus.FLR1 = 1'b1; bus.FLR3 = 1'b1;
      bus.Btn = 3'b011;
      @(negedge clk);
      bus.Btn = 3'b000;
      wait_req(3'b010, 6, "t7_req_down");
      bus.FLR1 = 1'b0; bus.FLR3 = 1'b0; bus.FLR2 = 1'b1; bus.Door = 1'b1;
      @(negedge clk);
      bus.Door = 1'b0;
      wait_req(3'b001, 12, "t7_req_next");
      bus.FLR2 = 1'b0; bus.FLR1 = 1'b1; bus.Door = 1'b1;
      @(negedge clk);
      chk("t7_all_served", bus.Pend, 3'b000);
      bus.Door = 1'b0;
      repeat (6) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
